// File: rtl/uio_cfg_pkg.sv
// rtl/uio_cfg_pkg.sv - shared constants and helpers for the uio configuration loader
// Contents: FSM state encodings, default WIDTH/TIMEOUT, constant clog2 helper.
package uio_cfg_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_CHECK  = 2'd3;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_TIMEOUT = 16;

   // Bits needed to hold values 0..value-1 (minimum 1 bit).
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uio_cfg_timer.sv
// rtl/uio_cfg_timer.sv - inter-bit idle counter for the uio configuration loader
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the counter this edge (wins over en)
//   en        : count one idle cycle; saturates at TIMEOUT-1, never wraps
//   expired   : counter currently holds TIMEOUT-1
module uio_cfg_timer
   import uio_cfg_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int TW = clog2(TIMEOUT);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] timer;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         timer <= '0;
      end else if (en && !expired) begin
         timer <= timer + 1'b1;
      end
   end

   assign expired = (timer == LAST);

endmodule

// File: rtl/uio_cfg_loader.sv
// rtl/uio_cfg_loader.sv - framed serial loader for the uio pin-enable vector
// Build option: define UIO_CFG_READBACK_EN to shift the old configuration out on sout.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   frame_start           : pulse that begins or restarts a frame
//   bit_valid, bit_data   : qualified serial bit, MSB first, then one even-parity bit
//   err_clr               : clears both sticky error flags
//   cfg_oe                : committed pin-enable vector
//   busy                  : frame in progress
//   done                  : one-cycle pulse after a successful commit
//   err_parity            : sticky parity failure
//   err_timeout           : sticky inter-bit timeout
//   sout                  : readback of the previous configuration (0 when disabled)
module uio_cfg_loader
   import uio_cfg_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             bit_valid,
   input  logic             bit_data,
   input  logic             err_clr,
   output logic [WIDTH-1:0] cfg_oe,
   output logic             busy,
   output logic             done,
   output logic             err_parity,
   output logic             err_timeout,
   output logic             sout
);

   localparam int CW = clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] shadow;
   logic [CW-1:0]    count;
   logic             parity_bit;
   logic             in_frame;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_expired;
   logic             parity_ok;

   assign in_frame  = (state == ST_SHIFT) || (state == ST_PARITY);
   // Even parity over data plus parity bit.
   assign parity_ok = ~^{shadow, parity_bit};

   // Timer only runs while waiting for a bit; any bit or restart rearms it.
   assign tmr_clr = !in_frame || frame_start || bit_valid;
   assign tmr_en  = in_frame && !bit_valid;

   uio_cfg_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         shadow      <= '0;
         count       <= '0;
         parity_bit  <= 1'b0;
         cfg_oe      <= '0;
         done        <= 1'b0;
         err_parity  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         done <= 1'b0;
         // Clear first so a same-cycle error below overrides it.
         if (err_clr) begin
            err_parity  <= 1'b0;
            err_timeout <= 1'b0;
         end
         if (frame_start) begin
            // Restart from any state; a pending CHECK is abandoned.
            state  <= ST_SHIFT;
            count  <= '0;
            shadow <= '0;
         end else begin
            case (state)
               ST_SHIFT: begin
                  if (bit_valid) begin
                     shadow <= {shadow[WIDTH-2:0], bit_data};
                     count  <= count + 1'b1;
                     if (count == CNT_LAST) state <= ST_PARITY;
                  end else if (tmr_expired) begin
                     err_timeout <= 1'b1;
                     shadow      <= '0;
                     state       <= ST_IDLE;
                  end
               end
               ST_PARITY: begin
                  if (bit_valid) begin
                     parity_bit <= bit_data;
                     state      <= ST_CHECK;
                  end else if (tmr_expired) begin
                     err_timeout <= 1'b1;
                     shadow      <= '0;
                     state       <= ST_IDLE;
                  end
               end
               ST_CHECK: begin
                  if (parity_ok) begin
                     cfg_oe <= shadow;
                     done   <= 1'b1;
                  end else begin
                     err_parity <= 1'b1;
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy = (state != ST_IDLE);

`ifdef UIO_CFG_READBACK_EN
   logic [WIDTH-1:0] readback;

   // Loaded at frame entry, so the host sees the old vector while writing the new one.
   always_ff @(posedge clk) begin
      if (rst) begin
         readback <= '0;
      end else if (frame_start) begin
         readback <= cfg_oe;
      end else if ((state == ST_SHIFT) && bit_valid) begin
         readback <= readback << 1;
      end
   end

   assign sout = (state == ST_SHIFT) ? readback[WIDTH-1] : 1'b0;
`else
   assign sout = 1'b0;
`endif

endmodule

// File: tb/tb_uio_cfg_loader.sv
// tb/tb_uio_cfg_loader.sv - self-checking bench for uio_cfg_loader
module tb_uio_cfg_loader;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             frame_start;
   logic             bit_valid;
   logic             bit_data;
   logic             err_clr;
   logic [WIDTH-1:0] cfg_oe;
   logic             busy;
   logic             done;
   logic             err_parity;
   logic             err_timeout;
   logic             sout;

   int checks = 0;
   int errors = 0;

   // Reference model state: what the host expects the block to hold.
   logic [7:0] exp_cfg;
   logic       exp_perr;
   logic       exp_tout;

   always #5 clk = ~clk;

   uio_cfg_loader #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .bit_valid   (bit_valid),
      .bit_data    (bit_data),
      .err_clr     (err_clr),
      .cfg_oe      (cfg_oe),
      .busy        (busy),
      .done        (done),
      .err_parity  (err_parity),
      .err_timeout (err_timeout),
      .sout        (sout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic rb_exp(input logic [7:0] old, input int idx);
`ifdef UIO_CFG_READBACK_EN
      return old[idx];
`else
      return 1'b0;
`endif
   endfunction

   task automatic send_bit(input logic b, input logic exp_sout);
      check("sout", sout, exp_sout);
      bit_valid = 1'b1;
      bit_data  = b;
      tick();
      bit_valid = 1'b0;
      bit_data  = 1'b0;
   endtask

   task automatic shift_bits(input logic [7:0] word, input int n, input int maxgap, input logic [7:0] old);
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(0, maxgap));
         send_bit(word[7-i], rb_exp(old, 7 - i));
      end
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic do_frame(input logic [7:0] word, input logic par, input int maxgap);
      logic [7:0] old;
      logic       ok;
      old = exp_cfg;
      ok  = ((^word) ^ par) == 1'b0;
      start_frame();
      check("busy_in_frame", busy, 1'b1);
      shift_bits(word, 8, maxgap, old);
      idle($urandom_range(0, maxgap));
      check("sout_parity_phase", sout, 1'b0);
      bit_valid = 1'b1;
      bit_data  = par;
      tick();
      bit_valid = 1'b0;
      bit_data  = 1'b0;
      check("done_at_check", done, 1'b0);
      check("cfg_before_commit", cfg_oe, old);
      tick();
      if (ok) exp_cfg = word;
      else    exp_perr = 1'b1;
      check("done_pulse", done, ok);
      check("cfg_oe", cfg_oe, exp_cfg);
      check("err_parity", err_parity, exp_perr);
      check("busy_after", busy, 1'b0);
      tick();
      check("done_single", done, 1'b0);
   endtask

   task automatic do_timeout(input int nbits, input logic clr_at_expiry);
      logic [7:0] old;
      old = exp_cfg;
      start_frame();
      shift_bits(8'($urandom), nbits, 2, old);
      idle(TIMEOUT - 1);
      check("tout_not_yet", err_timeout, exp_tout);
      check("tout_busy_before", busy, 1'b1);
      err_clr = clr_at_expiry;
      tick();
      err_clr  = 1'b0;
      exp_tout = 1'b1;
      if (clr_at_expiry) exp_perr = 1'b0;
      check("err_timeout", err_timeout, 1'b1);
      check("tout_busy_after", busy, 1'b0);
      check("tout_cfg_kept", cfg_oe, exp_cfg);
      check("tout_err_parity", err_parity, exp_perr);
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      tick();
      err_clr  = 1'b0;
      exp_perr = 1'b0;
      exp_tout = 1'b0;
      check("clr_parity", err_parity, 1'b0);
      check("clr_timeout", err_timeout, 1'b0);
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; err_clr = 1'b0;
      exp_cfg = 8'h00; exp_perr = 1'b0; exp_tout = 1'b0;
      idle(2);
      rst = 1'b0;
      check("rst_cfg", cfg_oe, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_perr", err_parity, 1'b0);
      check("rst_tout", err_timeout, 1'b0);
      check("rst_sout", sout, 1'b0);

      // Ignored bits while idle.
      bit_valid = 1'b1; bit_data = 1'b1;
      idle(3);
      bit_valid = 1'b0; bit_data = 1'b0;
      check("idle_ignore_busy", busy, 1'b0);
      check("idle_ignore_cfg", cfg_oe, 8'h00);

      // Commit and bad parity.
      do_frame(8'hA5, 1'b0, 0);
      do_frame(8'h3C, 1'b1, 1);
      clear_errors();

      // Timeout after 3 bits, then timeout with err_clr at the expiry edge.
      do_timeout(3, 1'b0);
      do_timeout(0, 1'b1);
      clear_errors();
      do_frame(8'h0F, 1'b0, 0);

      // Restart mid-frame.
      start_frame();
      shift_bits(8'hFF, 5, 0, exp_cfg);
      do_frame(8'h81, 1'b0, 0);
      check("restart_perr", err_parity, 1'b0);
      check("restart_tout", err_timeout, 1'b0);

      // frame_start during CHECK abandons the commit.
      start_frame();
      shift_bits(8'h55, 8, 0, exp_cfg);
      bit_valid = 1'b1; bit_data = 1'b0;
      tick();
      bit_valid = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("chk_restart_done", done, 1'b0);
      check("chk_restart_cfg", cfg_oe, exp_cfg);
      check("chk_restart_busy", busy, 1'b1);
      tick();
      check("chk_restart_done2", done, 1'b0);

      // Readback of old vector while writing the new one.
      do_frame(8'hC3, 1'b0, 0);
      do_frame(8'h18, 1'b0, 2);

      // Reset mid-frame with a sticky error pending.
      do_frame(8'h81, 1'b1, 0);
      start_frame();
      shift_bits(8'h81, 3, 0, exp_cfg);
      bit_valid = 1'b1; bit_data = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
      exp_cfg = 8'h00; exp_perr = 1'b0; exp_tout = 1'b0;
      check("mid_rst_cfg", cfg_oe, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_perr", err_parity, 1'b0);
      check("mid_rst_tout", err_timeout, 1'b0);
      check("mid_rst_sout", sout, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bit_valid = 1'b1; bit_data = i[0];
         tick();
      end
      bit_valid = 1'b0; bit_data = 1'b0;
      check("post_rst_cfg", cfg_oe, 8'h00);
      check("post_rst_busy", busy, 1'b0);

      // Randomized mix of good frames, bad parity and timeouts.
      for (int n = 0; n < 30; n++) begin
         int r;
         logic [7:0] w;
         r = $urandom_range(0, 5);
         w = 8'($urandom);
         if (r == 0) begin
            do_timeout($urandom_range(0, 8), 1'($urandom_range(0, 1)));
         end else begin
            do_frame(w, (^w) ^ (r == 1), 3);
         end
         if ($urandom_range(0, 1) == 1) clear_errors();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
